snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
- Parametrised snake game core: grid size, maximum length, step rate and wall mode are all configurable.
- Owns the body FIFO, the occupancy map, the latched direction, the apple placement (LFSR plus free-cell scan) and the game-over/win status.
- Sits between the push-button inputs and the VGA colour mixer, and serves a registered cell-query port indexed by the pixel counters.
- Runs entirely in the 25 MHz VGA domain; no clock crossing.

Parameters:
- GRID_W, 16, grid columns including the border ring.
- GRID_H, 15, grid rows including the border ring.
- CW, 4, coordinate width; must satisfy 2^CW >= max(GRID_W, GRID_H).
- MAX_LEN, 16, body FIFO depth; reaching this length is a win. Must be a power of two and < (GRID_W-2)*(GRID_H-2).
- INIT_LEN, 3, snake length after reset (>= 2).
- TICK_DIV, 7500000, clk_25 cycles per game step; must be > GRID_W*GRID_H+8.
- WRAP, 0, 0 = border kills; 1 = head wraps across the interior.
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR.

Ports:
- clk_25  in  1  25 MHz clock.
- reset  in  1  asynchronous, active-low reset.
- btn_n  in  4  active-low buttons: [0] left, [1] up, [2] right, [3] down.
- query_x  in  CW  cell column to look up.
- query_y  in  CW  cell row to look up.
- q_snake  out  1  queried cell is occupied by the body (registered).
- q_apple  out  1  queried cell is the apple (registered).
- q_border  out  1  queried cell is on the border ring (registered).
- head_x, head_y  out  CW each  current head cell.
- apple_x, apple_y  out  CW each  current apple cell.
- length  out  $clog2(MAX_LEN)+1  current body length.
- game_over  out  1  sticky until reset.
- game_win  out  1  sticky until reset.
- step_pulse  out  1  one-cycle strobe on each committed step.

Behaviour:
- Reset values (reset low, asynchronous):
  - Body cells are (2+i, 2) for i = 0..INIT_LEN-1; tail at (2,2); head at (INIT_LEN+1, 2).
  - Map holds exactly those bits; length = INIT_LEN; direction = right.
  - Apple at (GRID_W-3, GRID_H-3); LFSR = LFSR_SEED; tick counter = 0; state = RUN.
  - game_over, game_win, step_pulse and all q_* outputs are 0.
- Tick generation: counter counts 0..TICK_DIV-1 and raises tick when it wraps. A tick is consumed only in RUN; ticks arriving in any other state are dropped.
- Direction request:
  - Sampled every cycle; valid only when exactly one btn_n bit is low.
  - A request is stored in pend_dir unless it is the reverse of last_dir, where last_dir is the direction actually used at the last committed step. Checking against last_dir means two quick presses within one tick cannot reverse the snake.
  - last_dir is set from pend_dir in STEP.
- States:
  - RUN: on tick go to STEP.
  - STEP: nxt = head + pend_dir.
    - WRAP=0: go to OVER if nxt lies on the border (x==0, x==GRID_W-1, y==0 or y==GRID_H-1).
    - WRAP=1: x = 0 maps to GRID_W-2, x = GRID_W-1 maps to 1; same rule for y.
  - CHECK (one cycle):
    - eat = (nxt == apple).
    - Self-hit = map[nxt] set, except when nxt == tail and eat == 0, since the tail vacates that cell this step.
    - Self-hit goes to OVER.
  - COMMIT:
    - Write nxt into the FIFO at head_ptr+1 and set map[nxt].
    - If !eat: clear map[tail] and increment tail_ptr.
    - If eat: length+1.
    - Pulse step_pulse.
    - If eat and the new length == MAX_LEN, go to WIN. Else if eat, go to APPLE. Otherwise go to RUN.
    - When nxt equals the tail cell and !eat, the set wins over the clear.
  - APPLE:
    - First cycle: candidate = (lfsr[CW-1:0], lfsr[2CW-1:CW]); any coordinate outside the interior [1..GRID_W-2] or [1..GRID_H-2] is forced to 1.
    - Each cycle: accept if map[candidate] is 0 and go to RUN. Otherwise advance x; past GRID_W-2 set x = 1 and advance y; past GRID_H-2 set y = 1.
    - Terminates within (GRID_W-2)*(GRID_H-2) cycles.
  - OVER / WIN: terminal; only reset leaves them. Pointers, map and apple are frozen.
- LFSR: x^16+x^14+x^13+x^11, advances every cycle.
- Query port: 1-cycle latency. q_* reflect the map and apple registers as they were at the cycle query_x/query_y were sampled.
- Out-of-range queries (x >= GRID_W or y >= GRID_H) return all q_* = 0.
- Reset asserted mid-step or mid-search aborts immediately to the reset image.

Test Plan:
- TICK_DIV=8, no buttons, WRAP=0 → head advances right one cell per step: (4,2), (5,2) … reaching (14,2); the next step sets game_over. Length stays 3.
- Force the apple to (5,2) via reset image GRID_W=8 → head reaches (5,2); length goes 3→4; the tail is not cleared that step; the new apple is a free interior cell within 36 cycles.
- Moving right, press up then left within one tick → step goes up. Left alone while moving right is rejected; direction stays right.
- WRAP=1, head at (14,5) moving right → next head is (1,5); game_over stays 0.
- Head steps into the cell the tail vacates the same step → no game_over. Step into a mid-body cell → game_over=1 and step_pulse does not fire.
- MAX_LEN=4, INIT_LEN=3, eat once → game_win=1 and the state freezes. Assert reset mid-APPLE → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: snake game core for a VGA-clocked playfield.
// Holds the body FIFO, the occupancy map, the latched direction, apple
// placement (LFSR seed plus free-cell scan) and the terminal status, and
// answers registered cell queries driven by the pixel counters.
module snake_engine #(
  parameter int          GRID_W    = 16,
  parameter int          GRID_H    = 15,
  parameter int          CW        = 4,
  parameter int          MAX_LEN   = 16,
  parameter int          INIT_LEN  = 3,
  parameter int          TICK_DIV  = 7500000,
  parameter int          WRAP      = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk_25,
  input  logic                       reset,
  input  logic [3:0]                 btn_n,
  input  logic [CW-1:0]              query_x,
  input  logic [CW-1:0]              query_y,
  output logic                       q_snake,
  output logic                       q_apple,
  output logic                       q_border,
  output logic [CW-1:0]              head_x,
  output logic [CW-1:0]              head_y,
  output logic [CW-1:0]              apple_x,
  output logic [CW-1:0]              apple_y,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       game_over,
  output logic                       game_win,
  output logic                       step_pulse
);

  localparam int PW     = $clog2(MAX_LEN);
  localparam int LW     = PW + 1;
  localparam int MW     = $clog2(GRID_W * GRID_H);
  localparam int MAP_SZ = 1 << MW;
  localparam int TW     = $clog2(TICK_DIV);

  localparam logic [CW-1:0] X_LO   = CW'(1);
  localparam logic [CW-1:0] X_HI   = CW'(GRID_W - 2);
  localparam logic [CW-1:0] X_EDGE = CW'(GRID_W - 1);
  localparam logic [CW-1:0] Y_LO   = CW'(1);
  localparam logic [CW-1:0] Y_HI   = CW'(GRID_H - 2);
  localparam logic [CW-1:0] Y_EDGE = CW'(GRID_H - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_RUN, S_STEP, S_CHECK, S_COMMIT, S_APPLE, S_OVER, S_WIN
  } state_t;

  typedef enum logic [1:0] {
    DIR_LEFT = 2'd0, DIR_UP = 2'd1, DIR_RIGHT = 2'd2, DIR_DOWN = 2'd3
  } dir_t;

  // Flat map index; the map is padded to a power of two so any index fits.
  function automatic logic [MW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return MW'(int'(y) * GRID_W + int'(x));
  endfunction

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  state_t            state, state_nxt;
  dir_t              pend_dir, last_dir, req_dir;
  logic              req_valid;
  logic [CW-1:0]     body_x [MAX_LEN];
  logic [CW-1:0]     body_y [MAX_LEN];
  logic [PW-1:0]     head_ptr, tail_ptr;
  logic [MAP_SZ-1:0] occ;
  logic [CW-1:0]     tail_x, tail_y;
  logic [CW-1:0]     step_x, step_y;
  logic              step_border;
  logic [CW-1:0]     nxt_x, nxt_y;
  logic              nxt_eat, self_hit, eat;
  logic [LW-1:0]     len_inc;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [15:0]       lfsr;
  logic [CW-1:0]     lfsr_x, lfsr_y;
  logic [CW-1:0]     scan_x, scan_y, cand_x, cand_y;
  logic              cand_free, apple_first;
  logic              q_in;
  logic [MW-1:0]     q_idx;

  assign head_x    = body_x[head_ptr];
  assign head_y    = body_y[head_ptr];
  assign tail_x    = body_x[tail_ptr];
  assign tail_y    = body_y[tail_ptr];
  assign game_over = (state == S_OVER);
  assign game_win  = (state == S_WIN);
  assign tick      = (tick_cnt == TICK_LAST);
  assign len_inc   = length + LW'(1);
  assign lfsr_x    = lfsr[CW-1:0];
  assign lfsr_y    = lfsr[2*CW-1:CW];
  assign nxt_eat   = (nxt_x == apple_x) && (nxt_y == apple_y);
  assign self_hit  = occ[cell_idx(nxt_x, nxt_y)] &&
                     !((nxt_x == tail_x) && (nxt_y == tail_y) && !nxt_eat);
  assign cand_free = !occ[cell_idx(cand_x, cand_y)];

  // Free-running step divider; the FSM only listens to it while in RUN.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + TW'(1);
  end

  // 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) that runs every cycle.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Decode a button request; only a single pressed button counts.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    case (~btn_n)
      4'b0001: req_dir = DIR_LEFT;
      4'b0010: req_dir = DIR_UP;
      4'b0100: req_dir = DIR_RIGHT;
      4'b1000: req_dir = DIR_DOWN;
      default: req_valid = 1'b0;
    endcase
  end

  // Latch the requested direction unless it would reverse the last real move.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) pend_dir <= DIR_RIGHT;
    else if (req_valid && (req_dir != reverse_dir(last_dir))) pend_dir <= req_dir;
  end

  // Candidate head cell for this step, folded across the interior when wrapping.
  always_comb begin
    step_x = head_x;
    step_y = head_y;
    case (pend_dir)
      DIR_LEFT:  step_x = head_x - CW'(1);
      DIR_UP:    step_y = head_y - CW'(1);
      DIR_RIGHT: step_x = head_x + CW'(1);
      DIR_DOWN:  step_y = head_y + CW'(1);
    endcase
    if (WRAP != 0) begin
      if (step_x == '0) step_x = X_HI;
      else if (step_x == X_EDGE) step_x = X_LO;
      if (step_y == '0) step_y = Y_HI;
      else if (step_y == Y_EDGE) step_y = Y_LO;
    end
    step_border = (step_x == '0) || (step_x == X_EDGE) ||
                  (step_y == '0) || (step_y == Y_EDGE);
  end

  // Apple candidate: clamped LFSR seed on the first search cycle, then the scan.
  always_comb begin
    cand_x = scan_x;
    cand_y = scan_y;
    if (apple_first) begin
      cand_x = (lfsr_x >= X_LO && lfsr_x <= X_HI) ? lfsr_x : X_LO;
      cand_y = (lfsr_y >= Y_LO && lfsr_y <= Y_HI) ? lfsr_y : Y_LO;
    end
  end

  // Game FSM state register.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) state <= S_RUN;
    else state <= state_nxt;
  end

  // Game FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (tick) state_nxt = S_STEP;
      S_STEP:   state_nxt = step_border ? S_OVER : S_CHECK;
      S_CHECK:  state_nxt = self_hit ? S_OVER : S_COMMIT;
      S_COMMIT: begin
        if (eat && (len_inc == LW'(MAX_LEN))) state_nxt = S_WIN;
        else if (eat) state_nxt = S_APPLE;
        else state_nxt = S_RUN;
      end
      S_APPLE:  if (cand_free) state_nxt = S_RUN;
      S_OVER:   state_nxt = S_OVER;
      S_WIN:    state_nxt = S_WIN;
      default:  state_nxt = S_RUN;
    endcase
  end

  // Body FIFO, occupancy map, apple and step bookkeeping; frozen in OVER/WIN.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= (i < INIT_LEN) ? CW'(2 + i) : '0;
        body_y[i] <= (i < INIT_LEN) ? CW'(2) : '0;
      end
      occ <= '0;
      for (int i = 0; i < INIT_LEN; i++) occ[cell_idx(CW'(2 + i), CW'(2))] <= 1'b1;
      head_ptr    <= PW'(INIT_LEN - 1);
      tail_ptr    <= '0;
      length      <= LW'(INIT_LEN);
      apple_x     <= CW'(GRID_W - 3);
      apple_y     <= CW'(GRID_H - 3);
      last_dir    <= DIR_RIGHT;
      nxt_x       <= '0;
      nxt_y       <= '0;
      eat         <= 1'b0;
      scan_x      <= X_LO;
      scan_y      <= Y_LO;
      apple_first <= 1'b0;
    end else begin
      case (state)
        S_STEP: begin
          nxt_x    <= step_x;
          nxt_y    <= step_y;
          last_dir <= pend_dir;
        end
        S_CHECK: eat <= nxt_eat;
        S_COMMIT: begin
          body_x[head_ptr + PW'(1)] <= nxt_x;
          body_y[head_ptr + PW'(1)] <= nxt_y;
          head_ptr <= head_ptr + PW'(1);
          if (!eat) begin
            occ[cell_idx(tail_x, tail_y)] <= 1'b0;
            tail_ptr <= tail_ptr + PW'(1);
          end else begin
            length <= len_inc;
          end
          occ[cell_idx(nxt_x, nxt_y)] <= 1'b1;
          apple_first <= 1'b1;
        end
        S_APPLE: begin
          apple_first <= 1'b0;
          if (cand_free) begin
            apple_x <= cand_x;
            apple_y <= cand_y;
          end else if (cand_x == X_HI) begin
            scan_x <= X_LO;
            scan_y <= (cand_y == Y_HI) ? Y_LO : cand_y + CW'(1);
          end else begin
            scan_x <= cand_x + CW'(1);
            scan_y <= cand_y;
          end
        end
        default: ;
      endcase
    end
  end

  // One-cycle strobe following each committed step.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) step_pulse <= 1'b0;
    else step_pulse <= (state == S_COMMIT);
  end

  assign q_in  = (int'(query_x) < GRID_W) && (int'(query_y) < GRID_H);
  assign q_idx = q_in ? cell_idx(query_x, query_y) : '0;

  // Registered cell lookup for the colour mixer; out-of-grid cells read as empty.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      q_snake  <= 1'b0;
      q_apple  <= 1'b0;
      q_border <= 1'b0;
    end else begin
      q_snake  <= q_in && occ[q_idx];
      q_apple  <= q_in && (query_x == apple_x) && (query_y == apple_y);
      q_border <= q_in && ((query_x == '0) || (query_x == X_EDGE) ||
                           (query_y == '0) || (query_y == Y_EDGE));
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed checks of snake_engine across four parameter sets
// (plain 16x15, wrapping 16x15, and two 8x5 grids with the apple beside the head).
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_a, btn_w, btn_e, btn_f;
  logic [3:0] qx, qy;

  logic       qs_a, qa_a, qb_a, go_a, gw_a, sp_a;
  logic [3:0] hx_a, hy_a, ax_a, ay_a;
  logic [4:0] len_a;
  logic       qs_w, qa_w, qb_w, go_w, gw_w, sp_w;
  logic [3:0] hx_w, hy_w, ax_w, ay_w;
  logic [4:0] len_w;
  logic       qs_e, qa_e, qb_e, go_e, gw_e, sp_e;
  logic [3:0] hx_e, hy_e, ax_e, ay_e;
  logic [3:0] len_e;
  logic       qs_f, qa_f, qb_f, go_f, gw_f, sp_f;
  logic [3:0] hx_f, hy_f, ax_f, ay_f;
  logic [2:0] len_f;

  int n_vec = 0;
  int n_err = 0;

  always #20 clk = ~clk;

  snake_engine #(.GRID_W(16), .GRID_H(15), .CW(4), .MAX_LEN(16), .INIT_LEN(4),
                 .TICK_DIV(8), .WRAP(0)) u_a (
    .clk_25(clk), .reset(reset), .btn_n(btn_a), .query_x(qx), .query_y(qy),
    .q_snake(qs_a), .q_apple(qa_a), .q_border(qb_a), .head_x(hx_a), .head_y(hy_a),
    .apple_x(ax_a), .apple_y(ay_a), .length(len_a), .game_over(go_a),
    .game_win(gw_a), .step_pulse(sp_a));

  snake_engine #(.GRID_W(16), .GRID_H(15), .CW(4), .MAX_LEN(16), .INIT_LEN(5),
                 .TICK_DIV(8), .WRAP(1)) u_w (
    .clk_25(clk), .reset(reset), .btn_n(btn_w), .query_x(qx), .query_y(qy),
    .q_snake(qs_w), .q_apple(qa_w), .q_border(qb_w), .head_x(hx_w), .head_y(hy_w),
    .apple_x(ax_w), .apple_y(ay_w), .length(len_w), .game_over(go_w),
    .game_win(gw_w), .step_pulse(sp_w));

  snake_engine #(.GRID_W(8), .GRID_H(5), .CW(4), .MAX_LEN(8), .INIT_LEN(3),
                 .TICK_DIV(8), .WRAP(0)) u_e (
    .clk_25(clk), .reset(reset), .btn_n(btn_e), .query_x(qx), .query_y(qy),
    .q_snake(qs_e), .q_apple(qa_e), .q_border(qb_e), .head_x(hx_e), .head_y(hy_e),
    .apple_x(ax_e), .apple_y(ay_e), .length(len_e), .game_over(go_e),
    .game_win(gw_e), .step_pulse(sp_e));

  snake_engine #(.GRID_W(8), .GRID_H(5), .CW(4), .MAX_LEN(4), .INIT_LEN(3),
                 .TICK_DIV(8), .WRAP(0)) u_f (
    .clk_25(clk), .reset(reset), .btn_n(btn_f), .query_x(qx), .query_y(qy),
    .q_snake(qs_f), .q_apple(qa_f), .q_border(qb_f), .head_x(hx_f), .head_y(hy_f),
    .apple_x(ax_f), .apple_y(ay_f), .length(len_f), .game_over(go_f),
    .game_win(gw_f), .step_pulse(sp_f));

  // One comparison: count it, and on mismatch count and report it.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Pulse reset low for two cycles with all buttons released.
  task automatic apply_reset();
    btn_a = 4'hF; btn_w = 4'hF; btn_e = 4'hF; btn_f = 4'hF;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Hold one button pattern on the chosen instance for a number of cycles.
  task automatic apply_stimulus(input int which, input logic [3:0] pattern, input int cycles);
    case (which)
      0: btn_a = pattern;
      1: btn_w = pattern;
      2: btn_e = pattern;
      default: btn_f = pattern;
    endcase
    repeat (cycles) @(negedge clk);
    btn_a = 4'hF; btn_w = 4'hF; btn_e = 4'hF; btn_f = 4'hF;
  endtask

  // Wait (bounded) for the next step_pulse of the chosen instance.
  task automatic wait_pulse(input int which, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = sp_a;
        1: seen = sp_w;
        2: seen = sp_e;
        default: seen = sp_f;
      endcase
    end
  endtask

  // Present a query and sample the registered answer one cycle later.
  task automatic query(input logic [3:0] x, input logic [3:0] y);
    qx = x;
    qy = y;
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    logic pulse_seen;
    logic found;
    int   pulses;

    reset = 1'b1;
    btn_a = 4'hF; btn_w = 4'hF; btn_e = 4'hF; btn_f = 4'hF;
    qx = 4'd0; qy = 4'd0;
    #5 reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset image");
    check_output("a_reset_head_x", hx_a, 5);
    check_output("a_reset_head_y", hy_a, 2);
    check_output("a_reset_apple_x", ax_a, 13);
    check_output("a_reset_apple_y", ay_a, 12);
    check_output("a_reset_length", len_a, 4);
    check_output("a_reset_over", go_a, 0);
    check_output("a_reset_win", gw_a, 0);
    check_output("a_reset_pulse", sp_a, 0);
    check_output("a_reset_q_border", qb_a, 0);
    check_output("a_reset_q_snake", qs_a, 0);
    check_output("w_reset_head_x", hx_w, 6);
    check_output("e_reset_apple_x", ax_e, 5);
    check_output("e_reset_apple_y", ay_e, 2);
    reset = 1'b1;

    $display("[TB] query port");
    query(4'd2, 4'd2);
    check_output("q_tail_snake", qs_a, 1);
    check_output("q_tail_border", qb_a, 0);
    query(4'd0, 4'd0);
    check_output("q_corner_border", qb_a, 1);
    check_output("q_corner_snake", qs_a, 0);
    query(4'd13, 4'd12);
    check_output("q_apple_hit", qa_a, 1);
    query(4'd15, 4'd3);
    check_output("q_right_edge_border", qb_a, 1);
    query(4'd3, 4'd15);
    check_output("q_out_of_range_border", qb_a, 0);
    check_output("q_out_of_range_snake", qs_a, 0);
    check_output("q_out_of_range_apple", qa_a, 0);

    $display("[TB] straight run into the right wall");
    for (int k = 1; k <= 9; k++) begin
      wait_pulse(0, seen);
      check_output("run_pulse", seen, 1);
      check_output("run_head_x", hx_a, 5 + k);
    end
    check_output("run_head_y", hy_a, 2);
    check_output("run_length", len_a, 4);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = go_a;
    end
    check_output("run_game_over", found, 1);
    check_output("run_frozen_head_x", hx_a, 14);

    $display("[TB] up then left within one tick");
    apply_reset();
    wait_pulse(0, seen);
    check_output("dir_first_head_x", hx_a, 6);
    apply_stimulus(0, 4'b1101, 2);
    apply_stimulus(0, 4'b1110, 2);
    wait_pulse(0, seen);
    check_output("dir_up_pulse", seen, 1);
    check_output("dir_up_head_x", hx_a, 6);
    check_output("dir_up_head_y", hy_a, 1);

    $display("[TB] reverse request rejected");
    apply_reset();
    wait_pulse(0, seen);
    apply_stimulus(0, 4'b1110, 2);
    wait_pulse(0, seen);
    check_output("rev_head_x", hx_a, 7);
    check_output("rev_head_y", hy_a, 2);

    $display("[TB] head enters the vacating tail cell");
    apply_reset();
    apply_stimulus(0, 4'b0111, 2);
    wait_pulse(0, seen);
    check_output("loop_down_head_y", hy_a, 3);
    apply_stimulus(0, 4'b1110, 2);
    wait_pulse(0, seen);
    check_output("loop_left_head_x", hx_a, 4);
    apply_stimulus(0, 4'b1101, 2);
    wait_pulse(0, seen);
    check_output("loop_up_pulse", seen, 1);
    check_output("loop_up_head_x", hx_a, 4);
    check_output("loop_up_head_y", hy_a, 2);
    check_output("loop_no_over", go_a, 0);
    check_output("loop_length", len_a, 4);
    query(4'd4, 4'd2);
    check_output("loop_head_cell_set", qs_a, 1);
    query(4'd3, 4'd2);
    check_output("loop_old_cell_clear", qs_a, 0);

    $display("[TB] wrap across the right border");
    apply_reset();
    for (int k = 1; k <= 9; k++) begin
      wait_pulse(1, seen);
      check_output("wrap_pulse", seen, 1);
    end
    check_output("wrap_head_x", hx_w, 1);
    check_output("wrap_head_y", hy_w, 2);
    check_output("wrap_no_over", go_w, 0);

    $display("[TB] head hits a mid-body cell");
    apply_reset();
    apply_stimulus(1, 4'b0111, 2);
    wait_pulse(1, seen);
    check_output("hit_down_head_y", hy_w, 3);
    apply_stimulus(1, 4'b1110, 2);
    wait_pulse(1, seen);
    check_output("hit_left_head_x", hx_w, 5);
    apply_stimulus(1, 4'b1101, 2);
    found = 1'b0;
    pulse_seen = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = go_w;
      if (sp_w) pulse_seen = 1'b1;
    end
    check_output("hit_game_over", found, 1);
    check_output("hit_no_pulse", pulse_seen, 0);
    check_output("hit_head_y", hy_w, 3);
    check_output("hit_length", len_w, 5);

    $display("[TB] eat the apple and re-place it");
    apply_reset();
    wait_pulse(2, seen);
    check_output("eat_pulse", seen, 1);
    check_output("eat_head_x", hx_e, 5);
    check_output("eat_length", len_e, 4);
    query(4'd2, 4'd2);
    check_output("eat_tail_kept", qs_e, 1);
    found = 1'b0;
    for (int i = 0; i < 35 && !found; i++) begin
      found = !((ax_e == 4'd5) && (ay_e == 4'd2));
      if (!found) @(negedge clk);
    end
    check_output("eat_apple_moved", found, 1);
    check_output("eat_apple_interior",
                 (ax_e >= 4'd1 && ax_e <= 4'd6 && ay_e >= 4'd1 && ay_e <= 4'd3), 1);
    check_output("eat_apple_free", (ay_e == 4'd2 && ax_e >= 4'd2 && ax_e <= 4'd5), 0);

    $display("[TB] reset during apple search");
    apply_reset();
    wait_pulse(2, seen);
    check_output("abort_grown", len_e, 4);
    reset = 1'b0;
    #1;
    check_output("abort_length", len_e, 3);
    check_output("abort_head_x", hx_e, 4);
    check_output("abort_apple_x", ax_e, 5);
    check_output("abort_apple_y", ay_e, 2);
    check_output("abort_pulse", sp_e, 0);
    check_output("abort_q_snake", qs_e, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] reaching MAX_LEN wins");
    apply_reset();
    wait_pulse(3, seen);
    check_output("win_pulse", seen, 1);
    check_output("win_flag", gw_f, 1);
    check_output("win_length", len_f, 4);
    pulses = 0;
    repeat (24) begin
      @(negedge clk);
      if (sp_f) pulses++;
    end
    check_output("win_frozen_pulses", pulses, 0);
    check_output("win_frozen_head_x", hx_f, 5);
    check_output("win_frozen_length", len_f, 4);
    check_output("win_still_set", gw_f, 1);
    check_output("win_not_over", go_f, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: sequence did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
